// File: rtl/turbo_iter_ctrl.sv
// turbo_iter_ctrl: iteration scheduler for the 4-bit SOVA turbo decoder.
// One soft-output datapath is time-shared between decoder 1 (natural order,
// o_dec_sel=0) and decoder 2 (interleaved order, o_dec_sel=1). Each frame runs
// up to MAX_ITER full iterations, each made of two half-passes. Every half-pass
// holds the datapath in restart for CLR_CYC cycles, waits for i_dp_done and
// then captures the hard decisions.
// Optional feature: define TURBO_EARLY_STOP_EN to end a frame early once two
// consecutive decoder-2 passes produce identical hard decisions.
module turbo_iter_ctrl #(
  parameter int MAX_ITER    = 8,
  parameter int ITER_W      = 4,
  parameter int TIMEOUT_CYC = 64,
  parameter int CLR_CYC     = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,        // asynchronous, active low
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_dp_done,
  input  logic [3:0]        i_sign_in,
  output logic              o_dp_rst_n,
  output logic              o_dec_sel,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ITER_W-1:0] o_iter_cnt,
  output logic [3:0]        o_hard_out
);

  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int CLR_W = $clog2(CLR_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_CAPT,
    S_FIN,
    S_ERR
  } state_t;

  state_t            r_state;
  logic [CLR_W-1:0]  r_clr_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_dp_rst_n;
  logic              r_dec_sel;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [ITER_W-1:0] r_iter_cnt;
  logic [3:0]        r_hard_out;

  logic [3:0]        w_hd;
  logic [ITER_W-1:0] w_iter_nxt;
  logic              w_last;
  logic              w_early;

  // Hard decision is the inverted sign bit of each soft output.
  assign w_hd       = ~i_sign_in;
  assign w_iter_nxt = r_iter_cnt + ITER_W'(1);
  assign w_last     = (w_iter_nxt == ITER_W'(MAX_ITER));

`ifdef TURBO_EARLY_STOP_EN
  logic [3:0] r_prev_hd;
  // Converged when this decoder-2 pass matches the previous one (needs one
  // completed iteration to compare against).
  assign w_early = (r_iter_cnt != '0) && (w_hd == r_prev_hd);
`else
  assign w_early = 1'b0;
`endif

  // Scheduler FSM; every output is a register updated on the state transition.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= S_IDLE;
      r_clr_cnt  <= '0;
      r_to_cnt   <= '0;
      r_dp_rst_n <= 1'b0;
      r_dec_sel  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_iter_cnt <= '0;
      r_hard_out <= '0;
`ifdef TURBO_EARLY_STOP_EN
      r_prev_hd  <= '0;
`endif
    end else begin
      // NOTE: non-blocking throughout; the pulse defaults below are overridden
      // by later assignments in the same cycle, so the last write wins.
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_dp_rst_n <= 1'b0;
          if (i_start) begin
            r_state    <= S_CLR;
            r_clr_cnt  <= '0;
            r_iter_cnt <= '0;
            r_dec_sel  <= 1'b0;
            r_busy     <= 1'b1;
`ifdef TURBO_EARLY_STOP_EN
            r_prev_hd  <= '0;
`endif
          end
        end
        S_CLR: begin
          if (i_abort) begin
            r_state <= S_ERR;
            r_err   <= 1'b1;
          end else if (r_clr_cnt == CLR_W'(CLR_CYC - 1)) begin
            r_state    <= S_RUN;
            r_dp_rst_n <= 1'b1;
            r_to_cnt   <= '0;
          end else begin
            r_clr_cnt <= r_clr_cnt + CLR_W'(1);
          end
        end
        S_RUN: begin
          // abort has priority over a simultaneous dp_done.
          if (i_abort || (!i_dp_done && r_to_cnt == TO_W'(TIMEOUT_CYC - 1))) begin
            r_state    <= S_ERR;
            r_err      <= 1'b1;
            r_dp_rst_n <= 1'b0;
          end else if (i_dp_done) begin
            r_state <= S_CAPT;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        S_CAPT: begin
          r_dp_rst_n <= 1'b0;
          r_clr_cnt  <= '0;
          if (i_abort) begin
            r_state <= S_ERR;
            r_err   <= 1'b1;
          end else begin
            r_hard_out <= w_hd;
            if (!r_dec_sel) begin
              r_dec_sel <= 1'b1;
              r_state   <= S_CLR;
            end else begin
              r_iter_cnt <= w_iter_nxt;
`ifdef TURBO_EARLY_STOP_EN
              r_prev_hd  <= w_hd;
`endif
              if (w_last || w_early) begin
                r_state <= S_FIN;
                r_done  <= 1'b1;
              end else begin
                r_dec_sel <= 1'b0;
                r_state   <= S_CLR;
              end
            end
          end
        end
        S_FIN: begin
          // abort is ignored here: the frame has already completed.
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        S_ERR: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_dp_rst_n <= 1'b0;
        end
      endcase
    end
  end

  assign o_dp_rst_n = r_dp_rst_n;
  assign o_dec_sel  = r_dec_sel;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_iter_cnt = r_iter_cnt;
  assign o_hard_out = r_hard_out;

endmodule
